// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver, with a bus slave register file and a level IRQ.
// Optional idle timeout flag is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned THRESH_RST     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_value_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  output logic [31:0] resp_value_o,
  output logic        resp_valid_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [31:0] AddrData   = 32'h0;
  localparam logic [31:0] AddrStatus = 32'h4;
  localparam logic [31:0] AddrThresh = 32'h8;
  localparam logic [31:0] AddrCtrl   = 32'hC;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    thresh_q, thresh_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_value_q, resp_value_d;

  logic [PW-1:0] level;
  logic          empty, full;
  logic          req_rd, req_wr;
  logic          push, pop, flush, clr_ovr, overflow;
  logic [7:0]    head_byte;
  logic          timeout;
  logic          lvl_hit;

  assign level     = wptr_q - rptr_q;
  assign empty     = (level == '0);
  assign full      = (level == PW'(DEPTH));
  assign head_byte = mem_q[rptr_q[AW-1:0]];

  // Partial strobes are neither read nor write: acknowledged with no effect.
  assign req_rd = req_valid_i && (req_wstrb_i == 4'h0);
  assign req_wr = req_valid_i && (req_wstrb_i == 4'hF);

  assign pop      = req_rd && (req_addr_i == AddrData) && !empty;
  assign flush    = req_wr && (req_addr_i == AddrCtrl) && req_value_i[0];
  assign clr_ovr  = req_wr && (req_addr_i == AddrCtrl) && req_value_i[1];
  assign overflow = rx_valid_i && full;
  // Flush takes priority over a same-cycle push, discarding the byte.
  assign push     = rx_valid_i && !full && !flush;

  assign lvl_hit     = (thresh_q != 8'd0) && (32'(level) >= 32'(thresh_q));
  assign irq_o       = lvl_hit | timeout;
  assign req_ready_o = 1'b1;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (push || pop || flush) begin
      idle_d = 32'd0;
    end else if (!empty && (idle_q != 32'(TIMEOUT_CYCLES))) begin
      idle_d = idle_q + 32'd1;
    end
    if (pop || flush) begin
      timeout_d = 1'b0;
    end else if (idle_d == 32'(TIMEOUT_CYCLES)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q    <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    overrun_d = overrun_q;
    thresh_d  = thresh_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) rptr_d = rptr_q + PW'(1);
    if (flush) rptr_d = wptr_q;
    if (clr_ovr) overrun_d = 1'b0;
    if (overflow) overrun_d = 1'b1;
    if (req_wr && (req_addr_i == AddrThresh)) thresh_d = req_value_i[7:0];
  end

  always_comb begin
    resp_valid_d = req_valid_i;
    resp_value_d = 32'd0;
    if (req_rd) begin
      case (req_addr_i)
        AddrData:   if (!empty) resp_value_d = {23'd0, 1'b1, head_byte};
        AddrStatus: resp_value_d = {16'd0, 8'(level), 3'd0, timeout, irq_o, overrun_q, full, empty};
        AddrThresh: resp_value_d = {24'd0, thresh_q};
        default:    resp_value_d = 32'd0;
      endcase
    end
  end

  // Storage is not reset; contents are only observable through the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rx_byte_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      overrun_q    <= 1'b0;
      thresh_q     <= 8'(THRESH_RST);
      resp_valid_q <= 1'b0;
      resp_value_q <= 32'd0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      overrun_q    <= overrun_d;
      thresh_q     <= thresh_d;
      resp_valid_q <= resp_valid_d;
      resp_value_q <= resp_value_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_value_o = resp_value_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a
// queue-based reference model; timeout expectations follow UART_RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TOUT  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [31:0] req_addr, req_value;
  logic [3:0]  req_wstrb;
  logic        req_valid;
  logic        req_ready, resp_valid, irq;
  logic [31:0] resp_value;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  byte unsigned q[$];
  bit           m_ovr;
  int           m_thr;
  int           m_idle;
  bit           m_tmo;

  uart_rx_fifo #(
    .DEPTH         (DEPTH),
    .THRESH_RST    (1),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_byte_i   (rx_byte),
    .rx_valid_i  (rx_valid),
    .req_addr_i  (req_addr),
    .req_value_i (req_value),
    .req_wstrb_i (req_wstrb),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .resp_value_o(resp_value),
    .resp_valid_o(resp_valid),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_irq();
    return ((m_thr != 0) && (q.size() >= m_thr)) || m_tmo;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_thr  = 1;
    m_idle = 0;
    m_tmo  = 1'b0;
  endfunction

  // One clock cycle: drive inputs, predict from the pre-edge model, then compare after the edge.
  task automatic step(input string tag, input bit rxv, input logic [7:0] rxb, input bit rv,
                      input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] val);
    bit          is_rd, is_wr, pop, flush, clr, ovf, acc;
    int          lvl;
    logic [31:0] exp_val;
    @(negedge clk);
    rx_valid  = rxv;
    rx_byte   = rxb;
    req_valid = rv;
    req_addr  = addr;
    req_wstrb = ws;
    req_value = val;
    is_rd   = rv && (ws == 4'h0);
    is_wr   = rv && (ws == 4'hF);
    lvl     = q.size();
    exp_val = 32'd0;
    if (is_rd) begin
      if (addr == 32'h0 && lvl != 0) exp_val = 32'h100 | 32'(q[0]);
      else if (addr == 32'h4)
        exp_val = (lvl << 8) | (32'(m_tmo) << 4) | (32'(m_irq()) << 3) | (32'(m_ovr) << 2)
                | (32'(lvl == DEPTH) << 1) | 32'(lvl == 0);
      else if (addr == 32'h8) exp_val = 32'(m_thr);
    end
    pop   = is_rd && addr == 32'h0 && lvl != 0;
    flush = is_wr && addr == 32'hC && val[0];
    clr   = is_wr && addr == 32'hC && val[1];
    ovf   = rxv && lvl == DEPTH;
    acc   = rxv && lvl != DEPTH && !flush;
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    if (acc) q.push_back(rxb);
    if (clr) m_ovr = 1'b0;
    if (ovf) m_ovr = 1'b1;
    if (is_wr && addr == 32'h8) m_thr = int'(val[7:0]);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    if (acc || pop || flush) m_idle = 0;
    else if (lvl != 0 && m_idle < TOUT) m_idle++;
    if (pop || flush) m_tmo = 1'b0;
    else if (m_idle == TOUT) m_tmo = 1'b1;
`endif
    @(posedge clk);
    #1;
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'(rv));
    check({tag, ".resp_value"}, resp_value, exp_val);
    check({tag, ".irq"}, 32'(irq), 32'(m_irq()));
  endtask

  task automatic push(input string tag, input logic [7:0] b);
    step(tag, 1'b1, b, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    step(tag, 1'b0, 8'h0, 1'b1, a, 4'h0, 32'h0);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] v);
    step(tag, 1'b0, 8'h0, 1'b1, a, 4'hF, v);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  ws;
    rst       = 1'b1;
    rx_byte   = 8'h0;
    rx_valid  = 1'b0;
    req_addr  = 32'h0;
    req_value = 32'h0;
    req_wstrb = 4'h0;
    req_valid = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.resp_valid", 32'(resp_valid), 32'd0);
    check("reset.resp_value", resp_value, 32'd0);
    check("reset.irq", 32'(irq), 32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic push / drain
    push("t1", 8'h41); push("t1", 8'h42); push("t1", 8'h43);
    for (int i = 0; i < 4; i++) rd("t1.data", 32'h0);
    rd("t1.status", 32'h4);

    // Overflow and overrun clear
    for (int i = 0; i <= DEPTH; i++) push("t2", 8'(i));
    rd("t2.status", 32'h4);
    for (int i = 0; i < DEPTH; i++) rd("t2.data", 32'h0);
    wr("t2.clr", 32'hC, 32'h2);
    rd("t2.status", 32'h4);

    // Threshold interrupt
    wr("t3.thr", 32'h8, 32'h4);
    for (int i = 0; i < 4; i++) push("t3", 8'(8'h60 + i));
    rd("t3.pop", 32'h0);
    idle("t3");
    wr("t3.flush", 32'hC, 32'h1);

    // Simultaneous push/pop and flush/push
    for (int i = 0; i < 15; i++) push("t4", 8'(8'h80 + i));
    step("t4.pushpop", 1'b1, 8'hAA, 1'b1, 32'h0, 4'h0, 32'h0);
    rd("t4.status", 32'h4);
    step("t4.flushpush", 1'b1, 8'hBB, 1'b1, 32'hC, 4'hF, 32'h1);
    rd("t4.status", 32'h4);
    step("t4.emptyrdpush", 1'b1, 8'hCC, 1'b1, 32'h0, 4'h0, 32'h0);
    rd("t4.data", 32'h0);
    step("t4.badstrb", 1'b0, 8'h0, 1'b1, 32'h8, 4'h3, 32'h7);
    rd("t4.unmapped", 32'h40);
    rd("t4.ctrlrd", 32'hC);

    // Asynchronous reset mid-burst
    wr("t5.thr", 32'h8, 32'h1);
    for (int i = 0; i < 9; i++) push("t5", 8'(i));
    rd("t5.status", 32'h4);
    #1 rst = 1'b1;
    #1;
    check("t5.async.resp_valid", 32'(resp_valid), 32'd0);
    check("t5.async.resp_value", resp_value, 32'd0);
    check("t5.async.irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    rd("t5.status", 32'h4);
    rd("t5.thresh", 32'h8);

    // Idle timeout (irq stays low when the feature is not built)
    wr("t6.thr", 32'h8, 32'h8);
    push("t6", 8'h55);
    for (int i = 0; i < TOUT + 5; i++) idle("t6.wait");
    rd("t6.pop", 32'h0);
    idle("t6");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'h0;
        4, 5:       a = 32'h4;
        6:          a = 32'h8;
        7:          a = 32'hC;
        default:    a = 32'h10;
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ws = 4'h0;
        9:                ws = 4'($urandom_range(1, 14));
        default:          ws = 4'hF;
      endcase
      if (a == 32'hC && ws == 4'hF && $urandom_range(0, 3) != 0) a = 32'h8;
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 4, a, ws,
           (a == 32'h8) ? 32'($urandom_range(0, 20)) : 32'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
